// File: rtl/conv_pipe_param_if.sv
// Stream bundle for conv_pipe_param: x and f load streams in, y result stream out.
// A word moves on a stream only on a clock edge where its valid and ready are both high.
interface conv_pipe_param_if #(
    parameter int DATA_WIDTH_X = 8,
    parameter int DATA_WIDTH_F = 8,
    parameter int ACC_SIZE     = 21
);
    logic                           s_valid_x;
    logic                           s_ready_x;
    logic signed [DATA_WIDTH_X-1:0] s_data_in_x;
    logic                           s_valid_f;
    logic                           s_ready_f;
    logic signed [DATA_WIDTH_F-1:0] s_data_in_f;
    logic                           m_valid_y;
    logic                           m_ready_y;
    logic signed [ACC_SIZE-1:0]     m_data_out_y;

    // slave is the convolution engine; master feeds samples and takes results
    modport slave (
        input  s_valid_x, s_data_in_x, s_valid_f, s_data_in_f, m_ready_y,
        output s_ready_x, s_ready_f, m_valid_y, m_data_out_y
    );
    modport master (
        output s_valid_x, s_data_in_x, s_valid_f, s_data_in_f, m_ready_y,
        input  s_ready_x, s_ready_f, m_valid_y, m_data_out_y
    );
endinterface

// File: rtl/conv_pipe_param.sv
// Valid-mode 1-D convolution: load x and f, then stream y[k] = sum x[k+i]*f[i].
// Optional: define CONV_PIPE_RELU_EN to clamp negative results to 0 in the final stage.
module conv_pipe_param #(
    parameter int DATA_WIDTH_X = 8,
    parameter int DATA_WIDTH_F = 8,
    parameter int X_SIZE       = 128,
    parameter int F_SIZE       = 32,
    parameter int ACC_SIZE     = 21
) (
    input  logic              clk,
    input  logic              reset,
    conv_pipe_param_if.slave  bus,
    output logic [1:0]        dbg_state
);
    localparam int LOG2F = $clog2(F_SIZE);
    localparam int NY    = X_SIZE - F_SIZE + 1;
    localparam int PW    = DATA_WIDTH_X + DATA_WIDTH_F;
    localparam int XAW   = $clog2(X_SIZE);
    localparam int FAW   = $clog2(F_SIZE);
    localparam int NODES = 2 * F_SIZE - 1;

    typedef enum logic [1:0] {LOAD = 2'd0, COMPUTE = 2'd1, DRAIN = 2'd2} state_t;

    state_t                         state_q, state_d;
    logic [XAW:0]                   cnt_x_q, cnt_x_d;
    logic [FAW:0]                   cnt_f_q, cnt_f_d;
    logic [XAW-1:0]                 idx_q, idx_d;
    logic [XAW-1:0]                 out_cnt_q, out_cnt_d;
    logic [LOG2F:0]                 vld_q, vld_d;
    logic signed [ACC_SIZE-1:0]     node_q [NODES];
    logic signed [ACC_SIZE-1:0]     node_d [NODES];
    logic signed [DATA_WIDTH_X-1:0] x_mem_q [X_SIZE];
    logic signed [DATA_WIDTH_F-1:0] f_mem_q [F_SIZE];

    logic x_full, f_full, rdy_x, rdy_f, x_we, f_we;
    logic advance, issue, y_fire, last_out;

    assign x_full   = (cnt_x_q == (XAW+1)'(X_SIZE));
    assign f_full   = (cnt_f_q == (FAW+1)'(F_SIZE));
    assign x_we     = bus.s_valid_x && rdy_x;
    assign f_we     = bus.s_valid_f && rdy_f;
    assign advance  = !(bus.m_valid_y && !bus.m_ready_y);
    assign y_fire   = bus.m_valid_y && bus.m_ready_y;
    assign last_out = y_fire && (out_cnt_q == XAW'(NY - 1));

    assign bus.s_ready_x    = rdy_x;
    assign bus.s_ready_f    = rdy_f;
    assign bus.m_valid_y    = vld_q[LOG2F];
    assign bus.m_data_out_y = node_q[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOAD;
            cnt_x_q   <= '0;
            cnt_f_q   <= '0;
            idx_q     <= '0;
            out_cnt_q <= '0;
            vld_q     <= '0;
            for (int n = 0; n < NODES; n++) node_q[n] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_x_q   <= cnt_x_d;
            cnt_f_q   <= cnt_f_d;
            idx_q     <= idx_d;
            out_cnt_q <= out_cnt_d;
            vld_q     <= vld_d;
            for (int n = 0; n < NODES; n++) node_q[n] <= node_d[n];
        end
    end

    // Sample memories carry no reset; write counters alone say what is valid.
    always_ff @(posedge clk) begin
        if (x_we) x_mem_q[cnt_x_q[XAW-1:0]] <= bus.s_data_in_x;
        if (f_we) f_mem_q[cnt_f_q[FAW-1:0]] <= bus.s_data_in_f;
    end

    always_comb begin
        cnt_x_d   = cnt_x_q;
        cnt_f_d   = cnt_f_q;
        idx_d     = idx_q;
        out_cnt_d = out_cnt_q;
        if (x_we) cnt_x_d = cnt_x_q + 1'b1;
        if (f_we) cnt_f_d = cnt_f_q + 1'b1;
        if (issue) idx_d = idx_q + 1'b1;
        if (state_q == LOAD) idx_d = '0;
        if (y_fire) out_cnt_d = out_cnt_q + 1'b1;
        if (last_out) begin
            cnt_x_d   = '0;
            cnt_f_d   = '0;
            out_cnt_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (cnt_x_d == (XAW+1)'(X_SIZE) && cnt_f_d == (FAW+1)'(F_SIZE)) state_d = COMPUTE;
            COMPUTE: if (issue && idx_q == XAW'(NY - 1)) state_d = DRAIN;
            DRAIN:   if (last_out) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        rdy_x     = (state_q == LOAD) && !x_full;
        rdy_f     = (state_q == LOAD) && !f_full;
        issue     = (state_q == COMPUTE) && advance;
        dbg_state = state_q;
    end

    // Heap-ordered adder tree: leaves F_SIZE-1.. hold products, node n sums 2n+1 and 2n+2.
    always_comb begin
        logic signed [DATA_WIDTH_X-1:0] xv;
        logic signed [DATA_WIDTH_F-1:0] fv;
        logic signed [PW-1:0]           prod;
        xv    = '0;
        fv    = '0;
        prod  = '0;
        vld_d = vld_q;
        for (int n = 0; n < NODES; n++) node_d[n] = node_q[n];
        if (advance) begin
            vld_d = {vld_q[LOG2F-1:0], issue};
            for (int n = 0; n < F_SIZE - 1; n++) node_d[n] = node_q[2*n+1] + node_q[2*n+2];
            for (int i = 0; i < F_SIZE; i++) begin
                xv   = x_mem_q[idx_q + XAW'(i)];
                fv   = f_mem_q[i];
                prod = PW'(xv) * PW'(fv);
                node_d[F_SIZE-1+i] = ACC_SIZE'(prod);
            end
`ifdef CONV_PIPE_RELU_EN
            if (node_d[0][ACC_SIZE-1]) node_d[0] = '0;
`endif
        end
    end
endmodule

// File: tb/tb_conv_pipe_param.sv
// Directed bench for conv_pipe_param: a default-sized instance and a 16/4 instance share
// stimulus; the one not under test is held in reset.
module tb_conv_pipe_param;
  localparam int XB = 128, FB = 32, AB = 21;
  localparam int XS = 16, FS = 4, AS = 18;

  logic clk = 1'b0;
  logic rst_b, rst_s, sel;
  logic s_valid_x, s_valid_f, m_ready;
  logic [7:0] s_data_x, s_data_f;
  logic [1:0] dbg_b, dbg_s;
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  conv_pipe_param_if #(.DATA_WIDTH_X(8), .DATA_WIDTH_F(8), .ACC_SIZE(AB)) bus_b ();
  conv_pipe_param_if #(.DATA_WIDTH_X(8), .DATA_WIDTH_F(8), .ACC_SIZE(AS)) bus_s ();

  assign bus_b.s_valid_x = s_valid_x;
  assign bus_b.s_data_in_x = s_data_x;
  assign bus_b.s_valid_f = s_valid_f;
  assign bus_b.s_data_in_f = s_data_f;
  assign bus_b.m_ready_y = m_ready;
  assign bus_s.s_valid_x = s_valid_x;
  assign bus_s.s_data_in_x = s_data_x;
  assign bus_s.s_valid_f = s_valid_f;
  assign bus_s.s_data_in_f = s_data_f;
  assign bus_s.m_ready_y = m_ready;

  conv_pipe_param #(.DATA_WIDTH_X(8), .DATA_WIDTH_F(8), .X_SIZE(XB), .F_SIZE(FB), .ACC_SIZE(AB))
    dut_b (.clk(clk), .reset(rst_b), .bus(bus_b), .dbg_state(dbg_b));
  conv_pipe_param #(.DATA_WIDTH_X(8), .DATA_WIDTH_F(8), .X_SIZE(XS), .F_SIZE(FS), .ACC_SIZE(AS))
    dut_s (.clk(clk), .reset(rst_s), .bus(bus_s), .dbg_state(dbg_s));

  logic obs_rx, obs_rf, obs_vy;
  logic signed [31:0] obs_y, y_b, y_s;
  logic [1:0] obs_st;
  assign y_b = 32'(bus_b.m_data_out_y);
  assign y_s = 32'(bus_s.m_data_out_y);
  assign obs_rx = sel ? bus_s.s_ready_x : bus_b.s_ready_x;
  assign obs_rf = sel ? bus_s.s_ready_f : bus_b.s_ready_f;
  assign obs_vy = sel ? bus_s.m_valid_y : bus_b.m_valid_y;
  assign obs_y = sel ? y_s : y_b;
  assign obs_st = sel ? dbg_s : dbg_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // mode 0 all ones, 1 ramp/impulse, 2 all -128, 3 small ramp with f = i+1
  function automatic logic [7:0] x_val(input int mode, input int n);
    case (mode)
      0: return 8'd1;
      1: return 8'(n - 64);
      2: return 8'h80;
      default: return 8'(n);
    endcase
  endfunction

  function automatic logic [7:0] f_val(input int mode, input int i);
    case (mode)
      0: return 8'd1;
      1: return (i == 0) ? 8'd1 : 8'd0;
      2: return 8'h80;
      default: return 8'(i + 1);
    endcase
  endfunction

  task automatic load(input int mode, input int f_delay);
    int nx = 0, nf = 0, cyc = 0;
    int xs = sel ? XS : XB;
    int fs = sel ? FS : FB;
    logic tx, tf;
    while ((nx < xs || nf < fs) && cyc < 1000) begin
      #1;
      s_valid_x = (nx < xs);
      s_data_x = x_val(mode, nx);
      s_valid_f = (nf < fs) && (cyc >= f_delay);
      s_data_f = f_val(mode, nf);
      @(negedge clk);
      tx = s_valid_x && obs_rx;
      tf = s_valid_f && obs_rf;
      @(posedge clk);
      if (tx) nx++;
      if (tf) nf++;
      cyc++;
    end
    check("load_words", nx + nf, xs + fs);
  endtask

  task automatic pulse_reset();
    #1;
    if (sel) rst_s = 1'b1; else rst_b = 1'b1;
    @(posedge clk);
    #1;
    if (sel) rst_s = 1'b0; else rst_b = 1'b0;
    @(negedge clk);
    check("rst_valid", obs_vy, 1'b0);
    check("rst_ready_x", obs_rx, 1'b1);
    check("rst_ready_f", obs_rf, 1'b1);
    check("rst_state", obs_st, 2'd0);
    @(posedge clk);
  endtask

  task automatic run_out(input int n, input bit rnd, input int lat, input int abort_at);
    int got = 0, cyc = 0, extra = 0;
    int comp_cyc = -1, first_cyc = -1, last_cyc = -1;
    bit stalled = 1'b0;
    logic [31:0] held = '0;
    logic [31:0] exp;
    while (got < n && cyc < 3000) begin
      #1;
      s_valid_x = rnd;
      s_valid_f = rnd;
      s_data_x = 8'h55;
      s_data_f = 8'h55;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (comp_cyc < 0 && obs_st == 2'd1) comp_cyc = cyc;
      if (stalled) begin
        check("stall_valid", obs_vy, 1'b1);
        check("stall_data", obs_y, held);
      end
      stalled = obs_vy && !m_ready;
      held = obs_y;
      if (obs_vy && m_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("y", obs_y, exp);
        got++;
      end
      @(posedge clk);
      cyc++;
      if (got == abort_at) begin
        pulse_reset();
        exp_q.delete();
        return;
      end
    end
    check("out_count", got, n);
    check("compute_entry", comp_cyc, 0);
    if (!rnd) begin
      check("latency", first_cyc - comp_cyc, lat);
      check("back_to_back", last_cyc - first_cyc, n - 1);
    end
    for (int t = 0; t < 8; t++) begin
      #1;
      m_ready = 1'b1;
      s_valid_x = 1'b0;
      s_valid_f = 1'b0;
      @(negedge clk);
      if (t == 0) begin
        check("end_state", obs_st, 2'd0);
        check("end_ready_x", obs_rx, 1'b1);
        check("end_ready_f", obs_rf, 1'b1);
      end
      if (obs_vy) extra++;
      @(posedge clk);
    end
    check("no_extra", extra, 0);
  endtask

  task automatic push_ramp();
    for (int k = 0; k < XB - FB + 1; k++) begin
`ifdef CONV_PIPE_RELU_EN
      exp_q.push_back((k < 64) ? 32'd0 : 32'(k - 64));
`else
      exp_q.push_back(32'(k - 64));
`endif
    end
  endtask

  task automatic push_const(input int n, input int v);
    for (int k = 0; k < n; k++) exp_q.push_back(32'(v));
  endtask

  initial begin
    sel = 1'b0;
    rst_b = 1'b1;
    rst_s = 1'b1;
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    s_data_x = '0;
    s_data_f = '0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready_x", obs_rx, 1'b1);
    check("reset_ready_f", obs_rf, 1'b1);
    check("reset_valid", obs_vy, 1'b0);
    check("reset_data", obs_y, 32'd0);
    check("reset_state", obs_st, 2'd0);
    @(posedge clk);
    #1 rst_b = 1'b0;

    // all ones, last x and last f words on the same cycle
    push_const(97, 32);
    load(0, XB - FB);
    run_out(97, 1'b0, 6, -1);

    // impulse filter over a ramp
    push_ramp();
    load(1, 0);
    run_out(97, 1'b0, 6, -1);

    // most negative operands, largest magnitude sum
    push_const(97, 524288);
    load(2, 0);
    run_out(97, 1'b0, 6, -1);

    // random backpressure, with stray valids during compute
    push_ramp();
    load(1, 0);
    run_out(97, 1'b1, 6, -1);

    // reset after 40 outputs, then a full fresh run
    push_const(97, 32);
    load(0, 0);
    run_out(97, 1'b0, 6, 40);
    push_ramp();
    load(1, 0);
    run_out(97, 1'b0, 6, -1);

    // small instance: y[k] = 10k + 20
    #1;
    rst_b = 1'b1;
    sel = 1'b1;
    @(posedge clk);
    #1 rst_s = 1'b0;
    for (int k = 0; k < XS - FS + 1; k++) exp_q.push_back(32'(10 * k + 20));
    load(3, 0);
    run_out(13, 1'b0, 3, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/conv_pipe_param.md
CONV_PIPE_PARAM -- requirements
Module: conv_pipe_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH_X, default 8: signed x sample width.
REQ-002 SHALL have parameter DATA_WIDTH_F, default 8: signed filter coefficient width.
REQ-003 SHALL have parameter X_SIZE, default 128: x vector length, power of two, > F_SIZE.
REQ-004 SHALL have parameter F_SIZE, default 32: filter length, power of two, >= 2.
REQ-005 SHALL have parameter ACC_SIZE, default 21: output width, >= DATA_WIDTH_X+DATA_WIDTH_F+log2(F_SIZE).
REQ-006 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have ports s_valid_x in 1, s_ready_x out 1, s_data_in_x in DATA_WIDTH_X: x load stream.
REQ-009 SHALL have ports s_valid_f in 1, s_ready_f out 1, s_data_in_f in DATA_WIDTH_F: filter load stream.
REQ-010 SHALL have ports m_valid_y out 1, m_ready_y in 1, m_data_out_y out ACC_SIZE signed: result stream.

Function
REQ-011 SHALL transfer a word on any port only on a cycle with valid and ready both high.
REQ-012 SHALL store x words at addresses 0..X_SIZE-1 and f words at 0..F_SIZE-1 in arrival order; x and f loads are independent.
REQ-013 SHALL hold s_ready_x high in LOAD until X_SIZE words are stored, s_ready_f likewise until F_SIZE words; each then drops low.
REQ-014 SHALL use states LOAD, COMPUTE, DRAIN; LOAD->COMPUTE on the cycle both memories are full.
REQ-015 SHALL in COMPUTE issue window indices k = 0..NY-1, NY = X_SIZE-F_SIZE+1, one per advancing cycle, then enter DRAIN.
REQ-016 SHALL compute y[k] = sum over i of x[k+i]*f[i], full-precision products, sign-extended to ACC_SIZE before the first addition.
REQ-017 SHALL pipeline as one product register stage plus log2(F_SIZE) adder-tree register stages; the final stage drives m_data_out_y.
REQ-018 SHALL have latency L = 1+log2(F_SIZE) cycles (6 at defaults) from issue of k to m_valid_y for y[k], absent backpressure.
REQ-019 SHALL advance the whole pipeline, including its per-stage valid bits, only when !(m_valid_y && !m_ready_y); otherwise freeze it, holding m_data_out_y stable.
REQ-020 SHALL sustain one result per cycle while m_ready_y is high.
REQ-021 SHALL leave DRAIN for LOAD on the cycle y[NY-1] is accepted, resetting both write counters so s_ready_x/s_ready_f rise the next cycle.
REQ-022 SHALL ignore s_valid_x/s_valid_f outside LOAD and after its memory is full.
REQ-023 SHALL accept a last x word and last f word arriving on the same cycle, entering COMPUTE the next cycle.

Reset
REQ-024 SHALL on reset drive s_ready_x=1, s_ready_f=1, m_valid_y=0, m_data_out_y=0, state LOAD, counters and pipeline valid bits 0.
REQ-025 SHALL let reset asserted mid-COMPUTE or mid-DRAIN discard all in-flight results, with no m_valid_y the cycle after reset.
REQ-026 SHALL not require memory contents to be cleared by reset.

Configuration
REQ-027 SHALL, with macro CONV_PIPE_RELU_EN defined, output max(y[k],0) by clamping negative sums to 0 in the final stage, with unchanged latency.
REQ-028 SHALL, without CONV_PIPE_RELU_EN, output the signed y[k] unmodified.

Verification
REQ-029 SHALL cover: defaults, x[n]=1 for all n, f[i]=1 for all i, m_ready_y=1 -> 97 outputs, each 32, first output 6 cycles after COMPUTE entry, back-to-back.
REQ-030 SHALL cover: x[n]=n-64, f[0]=1, other f=0 -> y[k]=k-64; y[0]=-64 without CONV_PIPE_RELU_EN, 0 with it.
REQ-031 SHALL cover: all x=-128, all f=-128 -> every y=524288, with no overflow at ACC_SIZE=21.
REQ-032 SHALL cover: m_ready_y toggled randomly with 50% duty -> exactly 97 outputs, in order, none lost or duplicated, data stable while stalled.
REQ-033 SHALL cover: reset pulsed at output 40 -> m_valid_y=0 next cycle, s_ready_x=s_ready_f=1, and a fresh load then produces a correct full run.
REQ-034 SHALL cover: X_SIZE=16, F_SIZE=4, ACC_SIZE=18, f={1,2,3,4}, x[n]=n -> 13 outputs, y[0]=20, y[12]=140, latency 3.
